uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Downstream buffer for the UART receiver: captures each completed byte plus its parity-error flag
//  and queues them in a circular FIFO for the host side.
//  Decouples byte arrival from host reads; flags bytes lost to a full queue with a sticky overrun bit.
// PARAMETERS
//  BITS_PER_DATA  8   width of received data word
//  DEPTH_LOG2     4   log2 of FIFO depth (default 16 entries)
// PORTS
//  clk          in   1                  system clock, all logic on posedge
//  reset        in   1                  synchronous, active-high
//  rx_data      in   BITS_PER_DATA      byte from receiver (valid when rx_done rises)
//  rx_done      in   1                  receiver byte-complete strobe (level may last >=1 cycle)
//  rx_error     in   1                  receiver parity error for the byte
//  rd_en        in   1                  host pop request
//  rd_data      out  BITS_PER_DATA      popped byte, registered
//  rd_err       out  1                  parity-error flag of popped byte
//  rd_valid     out  1                  1-cycle pulse: rd_data/rd_err updated
//  empty        out  1                  level == 0
//  full         out  1                  level == 2**DEPTH_LOG2
//  level        out  DEPTH_LOG2+1       entries currently stored
//  overrun      out  1                  sticky: byte dropped while full
//  clr_overrun  in   1                  clears overrun
// BEHAVIOUR
//  - Reset (sync): wr_ptr=rd_ptr=0, level=0, empty=1, full=0, rd_data=0, rd_err=0, rd_valid=0,
//    overrun=0, rx_done edge register=0; storage contents don't-care.
//  - Write: on rising edge of rx_done (rx_done=1 and previous-cycle rx_done=0), store {rx_error,rx_data}
//    at wr_ptr, wr_ptr+1. Held rx_done produces exactly one write.
//  - Read: rd_en=1 with level>0 -> rd_data/rd_err <= entry at rd_ptr, rd_ptr+1, rd_valid=1 next cycle
//    (latency 1). rd_en with empty -> ignored, rd_valid=0, rd_data holds.
//  - Pointers DEPTH_LOG2 bits, wrap modulo depth; level is DEPTH_LOG2+1 bits, never exceeds depth.
//  - Simultaneous write+read, level>0: both performed, level unchanged.
//  - Simultaneous write+read, full: read frees slot, write accepted, overrun not set.
//  - Simultaneous write+read, empty: write accepted, read ignored (no bypass), level becomes 1.
//  - Write while full without read: byte dropped, pointers unchanged, overrun<=1.
//  - clr_overrun and new overrun same cycle: overrun stays 1 (set wins).
//  - Reset mid-operation: queue flushed in 1 cycle; a rx_done high during reset release
//    is not treated as a rising edge (edge register loads rx_done during reset).
//  - empty/full/level registered, consistent with pointers every cycle.
// CONFIGURATION
//  RX_FIFO_OVERRUN_CNT_EN defined: extra port overrun_cnt out 8 -- count of dropped bytes,
//    saturates at 255, reset to 0 by reset or clr_overrun (increment wins over clear same cycle,
//    giving 1).
//  Undefined: no overrun_cnt port, no counter logic; all other behaviour identical.
// TESTING
//  1 reset, no traffic -> empty=1, full=0, level=0, overrun=0, rd_valid=0.
//  2 push 0xA5 (err=0) then 0x3C (err=1), then rd_en x2 -> rd_data 0xA5/rd_err 0, then 0x3C/1,
//    rd_valid each 1 cycle after rd_en, empty=1.
//  3 rx_done held high 5 cycles with 0x11 -> level=1 only.
//  4 push 17 bytes 0x00..0x10 (depth 16) -> full=1 at 16th, 0x10 dropped, overrun=1
//    (overrun_cnt=1 with macro); pops return 0x00..0x0F in order.
//  5 full FIFO, write edge and rd_en same cycle -> level stays 16, overrun stays 0, new byte last out.
//  6 push 20, pop 20 interleaved across wrap -> FIFO order preserved; mid-stream reset -> level=0 next
//    cycle; rd_en on empty -> rd_valid=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: queues received bytes plus parity flag for the host; sticky overrun on dropped bytes.
// Define RX_FIFO_OVERRUN_CNT_EN to add the 8-bit saturating dropped-byte counter port overrun_cnt.
module uart_rx_fifo #(
    parameter int unsigned BITS_PER_DATA = 8,
    parameter int unsigned DEPTH_LOG2    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BITS_PER_DATA-1:0] rx_data,
    input  logic                     rx_done,
    input  logic                     rx_error,
    input  logic                     rd_en,
    output logic [BITS_PER_DATA-1:0] rd_data,
    output logic                     rd_err,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [DEPTH_LOG2:0]      level,
    output logic                     overrun,
    input  logic                     clr_overrun
`ifdef RX_FIFO_OVERRUN_CNT_EN
    ,
    output logic [7:0]               overrun_cnt
`endif
);
    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LvlFull = (DEPTH_LOG2 + 1)'(Depth);
    localparam logic [DEPTH_LOG2:0]   LvlOne  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PtrOne  = DEPTH_LOG2'(1);

    logic [BITS_PER_DATA:0]  mem [Depth];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
    logic                    rx_done_q;
    logic                    wr_edge, do_rd, do_wr, drop;
    logic [DEPTH_LOG2:0]     level_d;

    always_comb begin
        wr_edge = rx_done & ~rx_done_q;
        do_rd   = rd_en & ~empty;
        // A read in the same cycle frees the slot, so a full queue still accepts the byte.
        do_wr   = wr_edge & (~full | do_rd);
        drop    = wr_edge & full & ~do_rd;
        level_d = level;
        if (do_wr && !do_rd) begin
            level_d = level + LvlOne;
        end else if (do_rd && !do_wr) begin
            level_d = level - LvlOne;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= {rx_error, rx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            rd_data   <= '0;
            rd_err    <= 1'b0;
            rd_valid  <= 1'b0;
            overrun   <= 1'b0;
            // Loading rx_done here keeps a strobe held across reset release from counting as an edge.
            rx_done_q <= rx_done;
        end else begin
            rx_done_q <= rx_done;
            rd_valid  <= do_rd;
            if (do_rd) begin
                {rd_err, rd_data} <= mem[rd_ptr_q];
                rd_ptr_q          <= rd_ptr_q + PtrOne;
            end
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            level <= level_d;
            empty <= (level_d == '0);
            full  <= (level_d == LvlFull);
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef RX_FIFO_OVERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_cnt <= '0;
        end else if (clr_overrun) begin
            overrun_cnt <= drop ? 8'd1 : 8'd0;
        end else if (drop && overrun_cnt != 8'hFF) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic against a queue-based model.
// Build with RX_FIFO_OVERRUN_CNT_EN defined to also check overrun_cnt.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_error;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       overrun;
    logic       clr_overrun;
`ifdef RX_FIFO_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt;
`endif

    uart_rx_fifo #(.BITS_PER_DATA(8), .DEPTH_LOG2(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .rx_error    (rx_error),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_err      (rd_err),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
`ifdef RX_FIFO_OVERRUN_CNT_EN
        ,
        .overrun_cnt (overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a plain queue of {err, data} plus the observable side state.
    logic [8:0] q[$];
    logic       m_prev;
    logic       m_ov;
    logic [7:0] m_rd_data;
    logic       m_rd_err;
    logic       m_rd_valid;
    int         m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rd_valid", {31'b0, rd_valid}, {31'b0, m_rd_valid});
        chk("rd_data", {24'b0, rd_data}, {24'b0, m_rd_data});
        chk("rd_err", {31'b0, rd_err}, {31'b0, m_rd_err});
        chk("level", {27'b0, level}, q.size());
        chk("empty", {31'b0, empty}, {31'b0, q.size() == 0});
        chk("full", {31'b0, full}, {31'b0, q.size() == 16});
        chk("overrun", {31'b0, overrun}, {31'b0, m_ov});
`ifdef RX_FIFO_OVERRUN_CNT_EN
        chk("overrun_cnt", {24'b0, overrun_cnt}, m_cnt);
`endif
    endtask

    task automatic cycle(input logic d, input logic [7:0] data, input logic e, input logic r,
                         input logic c);
        bit         wr, rd, dropped;
        logic [8:0] ent;
        rx_done = d; rx_data = data; rx_error = e; rd_en = r; clr_overrun = c;
        wr      = d && !m_prev;
        rd      = r && (q.size() > 0);
        dropped = wr && (q.size() == 16) && !rd;
        m_rd_valid = rd;
        if (rd) begin
            ent = q.pop_front();
            m_rd_err  = ent[8];
            m_rd_data = ent[7:0];
        end
        if (wr && !dropped) q.push_back({e, data});
        if (dropped) m_ov = 1'b1;
        else if (c) m_ov = 1'b0;
        if (c) m_cnt = dropped ? 1 : 0;
        else if (dropped && m_cnt < 255) m_cnt++;
        m_prev = d;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset(input logic d);
        reset = 1'b1; rx_done = d; rd_en = 1'b0; clr_overrun = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        m_prev = d; m_ov = 1'b0; m_rd_data = '0; m_rd_err = 1'b0; m_rd_valid = 1'b0; m_cnt = 0;
        check_all();
    endtask

    task automatic push(input logic [7:0] data, input logic e);
        cycle(1'b1, data, e, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rx_data = '0; rx_done = 1'b0; rx_error = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0;
        reset = 1'b1;
        m_prev = 1'b0;

        // Reset state
        do_reset(1'b0);
        chk("t1_empty", {31'b0, empty}, 32'd1);
        chk("t1_level", {27'b0, level}, 32'd0);

        // Two bytes in, two out, with parity flags
        push(8'hA5, 1'b0);
        push(8'h3C, 1'b1);
        pop();
        chk("t2_data0", {24'b0, rd_data}, 32'hA5);
        chk("t2_err0", {31'b0, rd_err}, 32'd0);
        pop();
        chk("t2_data1", {24'b0, rd_data}, 32'h3C);
        chk("t2_err1", {31'b0, rd_err}, 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t2_valid_drop", {31'b0, rd_valid}, 32'd0);

        // Held rx_done gives one write
        repeat (5) cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t3_level", {27'b0, level}, 32'd1);
        pop();

        // Overfill by one
        do_reset(1'b0);
        for (int i = 0; i < 17; i++) begin
            push(8'(i), 1'b0);
            if (i == 15) chk("t4_full16", {31'b0, full}, 32'd1);
        end
        chk("t4_overrun", {31'b0, overrun}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            pop();
            chk("t4_order", {24'b0, rd_data}, i);
        end

        // Full with simultaneous write and read
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t5_level", {27'b0, level}, 32'd16);
        chk("t5_overrun", {31'b0, overrun}, 32'd0);
        for (int i = 0; i < 16; i++) pop();
        chk("t5_last", {24'b0, rd_data}, 32'h77);

        // Drop and clear in the same cycle: set wins
        for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        chk("t_setwins", {31'b0, overrun}, 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("t_clr", {31'b0, overrun}, 32'd0);

        // Interleaved traffic across pointer wrap, then mid-stream reset
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'(8'h40 + i), i[0], (i >= 3) ? 1'b1 : 1'b0, 1'b0);
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        while (q.size() > 0) pop();
        for (int i = 0; i < 5; i++) push(8'(8'h90 + i), 1'b0);
        do_reset(1'b0);
        chk("t6_reset_level", {27'b0, level}, 32'd0);
        pop();
        chk("t6_empty_rd", {31'b0, rd_valid}, 32'd0);
        do_reset(1'b1);
        cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        chk("t6_rst_edge", {27'b0, level}, 32'd0);

        // Random traffic: write-heavy then read-heavy phases
        for (int i = 0; i < 600; i++) begin
            logic r;
            if ((i / 100) % 2 == 0) r = ($urandom_range(0, 3) == 0);
            else                    r = ($urandom_range(0, 3) != 0);
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), r,
                  1'($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
